// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator for the registered ALU wrapper.
// Accepts one command at a time, drives the wrapper operands and waits LAT
// edges. It then captures the result and flags and presents them on a
// response channel.
// Optional feature macro: ALU_SEQ_STICKY_FLAGS_EN (accumulated flag history).
module alu_op_sequencer #(
    parameter int unsigned N     = 32,
    parameter int unsigned LAT   = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [N-1:0]     cmd_a,
    input  logic [N-1:0]     cmd_b,
    input  logic [3:0]       cmd_s,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [3:0]       alu_s,
    input  logic [N-1:0]     alu_result,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_data,
    output logic [3:0]       rsp_flags,
    output logic [CNT_W-1:0] ops_done,
    output logic [3:0]       sticky_flags,
    input  logic             sticky_clr
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0]       LAT_CNT = 4'(LAT);
    localparam logic [CNT_W-1:0] OPS_ONE = CNT_W'(1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wcnt;
    logic       accept;
    logic       capture;
    logic       rsp_done;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake strobes
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wcnt == LAT_CNT) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latency counter: cleared on accept, counts edges while waiting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt <= '0;
        end else if (accept) begin
            wcnt <= '0;
        end else if (state == WAIT) begin
            wcnt <= wcnt + 4'd1;
        end
    end

    // Operand registers toward the wrapper, held until the next accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_a <= '0;
            alu_b <= '0;
            alu_s <= '0;
        end else if (accept) begin
            alu_a <= cmd_a;
            alu_b <= cmd_b;
            alu_s <= cmd_s;
        end
    end

    // Response capture and valid flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_valid <= 1'b0;
        end else if (capture) begin
            rsp_data  <= alu_result;
            rsp_flags <= alu_flags;
            rsp_valid <= 1'b1;
        end else if (rsp_done) begin
            rsp_valid <= 1'b0;
        end
    end

    // Completed-response counter, wraps silently
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ops_done <= '0;
        end else if (rsp_done) begin
            ops_done <= ops_done + OPS_ONE;
        end
    end

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    // Sticky flag accumulation; a clear on a capture edge keeps only that capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_flags <= '0;
        end else if (sticky_clr) begin
            sticky_flags <= capture ? alu_flags : 4'b0000;
        end else if (capture) begin
            sticky_flags <= sticky_flags | alu_flags;
        end
    end
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = sticky_clr;
    assign sticky_flags      = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer with a behavioural LAT=2 ALU wrapper model.
module tb_alu_op_sequencer;

    localparam int N     = 32;
    localparam int LAT   = 2;
    localparam int CNT_W = 4;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready;
    logic [N-1:0]     cmd_a, cmd_b;
    logic [3:0]       cmd_s;
    logic [N-1:0]     alu_a, alu_b;
    logic [3:0]       alu_s;
    logic [N-1:0]     alu_result;
    logic [3:0]       alu_flags;
    logic             rsp_valid, rsp_ready;
    logic [N-1:0]     rsp_data;
    logic [3:0]       rsp_flags;
    logic [CNT_W-1:0] ops_done;
    logic [3:0]       sticky_flags;
    logic             sticky_clr;

    alu_op_sequencer #(.N(N), .LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_s(cmd_s),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .ops_done(ops_done), .sticky_flags(sticky_flags), .sticky_clr(sticky_clr)
    );

    always #5 clk = ~clk;

    // Behavioural wrapper: flags {ovf, carry, zero, neg}
    function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] s);
        logic [32:0] w;
        logic [31:0] r;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        case (s)
            4'h0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0]; c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'h1: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[31:0]; c = w[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'h2: r = a & b;
            4'h3: r = a | b;
            default: r = a ^ b;
        endcase
        return {v, c, (r == 32'h0), r[31], r};
    endfunction

    logic [35:0] pipe1 = '0, pipe2 = '0;
    always_ff @(posedge clk) begin
        pipe1 <= alu_f(alu_a, alu_b, alu_s);
        pipe2 <= pipe1;
    end
    assign alu_result = pipe2[31:0];
    assign alu_flags  = pipe2[35:32];

    int               passed = 0;
    int               total  = 0;
    logic [CNT_W-1:0] exp_ops = '0;
    logic [3:0]       exp_sticky = 4'b0000;
    bit               seen_wrap = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Wait for the response, optionally stall, then hand it off
    task automatic wait_rsp(input logic [31:0] ed, input logic [3:0] ef,
                            input bit clr_cap, input int stall);
        int n;
        logic [CNT_W-1:0] prev;
        n = 0;
        while (!rsp_valid && n < 20) begin
            if (clr_cap && n == LAT) sticky_clr = 1'b1;
            @(posedge clk); #1;
            sticky_clr = 1'b0;
            n++;
            if (!rsp_valid) check("cmd_ready_busy", cmd_ready, 1'b0);
        end
        check("rsp_latency", n, LAT + 1);
        check("rsp_data", rsp_data, ed);
        check("rsp_flags", rsp_flags, ef);
        if (clr_cap) exp_sticky = STICKY ? ef : 4'b0000;
        else if (STICKY) exp_sticky = exp_sticky | ef;
        check("sticky_flags", sticky_flags, exp_sticky);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_valid", rsp_valid, 1'b1);
            check("stall_data", rsp_data, ed);
            check("stall_ready", cmd_ready, 1'b0);
        end
        prev = ops_done;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_ops = exp_ops + 1'b1;
        check("rsp_valid_drop", rsp_valid, 1'b0);
        check("ops_done", ops_done, exp_ops);
        if (prev == 4'hF && ops_done == 4'h0) seen_wrap = 1'b1;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                          input logic [31:0] ed, input logic [3:0] ef, input bit clr_cap);
        check("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_s = s;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("alu_a", alu_a, a);
        check("alu_b", alu_b, b);
        check("alu_s", alu_s, s);
        wait_rsp(ed, ef, clr_cap, 0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  s;
        logic [31:0] data;
        logic [3:0]  flags;
    } vec_t;
    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 4'h0, 32'h0000_0008, 4'b0000};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 4'h0, 32'h0000_0000, 4'b0110};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 4'h0, 32'h8000_0000, 4'b1001};
        vecs[3] = '{32'h0000_0005, 32'h0000_0005, 4'h1, 32'h0000_0000, 4'b0010};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 4'h1, 32'h7FFF_FFFF, 4'b1000};
        vecs[5] = '{32'hFFFF_FFFF, 32'h8000_0000, 4'h2, 32'h8000_0000, 4'b0001};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 4'h3, 32'h0000_0000, 4'b0010};
        vecs[7] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 4'hF, 32'hFFFF_FFFF, 4'b0001};

        rst = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_s = '0;
        rsp_ready = 1'b0; sticky_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_alu_a", alu_a, 0);
        check("reset_alu_b", alu_b, 0);
        check("reset_ops_done", ops_done, 0);
        check("reset_sticky", sticky_flags, 0);

        // Reset asserted mid-WAIT at edge k+1
        begin
            bit saw_valid;
            saw_valid = 1'b0;
            cmd_valid = 1'b1; cmd_a = 32'h1234_5678; cmd_b = 32'h1; cmd_s = 4'h0;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            check("midrst_accept", alu_a, 32'h1234_5678);
            @(posedge clk); #1;
            rst = 1'b0;
            #1;
            check("midrst_alu_a", alu_a, 0);
            check("midrst_alu_b", alu_b, 0);
            check("midrst_alu_s", alu_s, 0);
            check("midrst_rsp_valid", rsp_valid, 1'b0);
            check("midrst_rsp_data", rsp_data, 0);
            check("midrst_rsp_flags", rsp_flags, 0);
            repeat (2) @(posedge clk);
            #1 rst = 1'b1;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk); #1;
                if (rsp_valid) saw_valid = 1'b1;
            end
            check("midrst_no_rsp", saw_valid, 1'b0);
            check("midrst_ops_done", ops_done, 0);
            check("midrst_cmd_ready", cmd_ready, 1'b1);
        end

        // First basic operation
        run_op(32'h5, 32'h3, 4'h0, 32'h8, 4'b0000, 1'b0);

        // Second command held while first is busy, response stalled 4 cycles
        check("hold_ready_pre", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_a = 32'd11; cmd_b = 32'd22; cmd_s = 4'h0;
        @(posedge clk); #1;
        cmd_a = 32'd33; cmd_b = 32'd44; cmd_s = 4'h1;
        check("hold_first_a", alu_a, 32'd11);
        wait_rsp(32'd33, 4'b0000, 1'b0, 4);
        check("hold_alu_a_after_hs", alu_a, 32'd11);
        check("hold_ready_after_hs", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("hold_second_a", alu_a, 32'd33);
        check("hold_second_s", alu_s, 4'h1);
        check("hold_second_busy", cmd_ready, 1'b0);
        wait_rsp(32'hFFFF_FFF5, 4'b0101, 1'b0, 0);

        // Sticky accumulation and clear-on-capture priority
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        exp_sticky = 4'b0000;
        check("sticky_cleared", sticky_flags, 4'b0000);
        run_op(32'h5, 32'h5, 4'h1, 32'h0, 4'b0010, 1'b0);
        run_op(32'h8000_0000, 32'h1, 4'h1, 32'h7FFF_FFFF, 4'b1000, 1'b0);
        check("sticky_or", sticky_flags, STICKY ? 4'b1010 : 4'b0000);
        run_op(32'hFFFF_FFFF, 32'h8000_0000, 4'h2, 32'h8000_0000, 4'b0001, 1'b1);
        check("sticky_clr_capture", sticky_flags, STICKY ? 4'b0001 : 4'b0000);

        // Table-driven vectors
        for (int i = 0; i < 8; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].data, vecs[i].flags, 1'b0);

        // Counter wrap with CNT_W=4
        for (int i = 0; i < 17; i++)
            run_op(vecs[i % 8].a, vecs[i % 8].b, vecs[i % 8].s,
                   vecs[i % 8].data, vecs[i % 8].flags, 1'b0);
        check("ops_wrap_seen", seen_wrap, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
